// File: rtl/geofence_feeder_pkg.sv
// geofence_feeder_pkg
//   Shared definitions for the geofence feeder: controller state encoding,
//   coordinate field widths, the number of records per object and the packed
//   point record that is buffered and streamed to the checker.
package geofence_feeder_pkg;

    // Controller state encoding
    localparam logic [1:0] COLLECT = 2'd0;
    localparam logic [1:0] LAUNCH  = 2'd1;
    localparam logic [1:0] WAIT    = 2'd2;
    localparam logic [1:0] REPORT  = 2'd3;

    typedef enum logic [1:0] {
        ST_COLLECT = COLLECT,
        ST_LAUNCH  = LAUNCH,
        ST_WAIT    = WAIT,
        ST_REPORT  = REPORT
    } state_e;

    // Coordinate widths
    localparam int XW  = 10;
    localparam int YW  = 10;
    localparam int RW  = 11;
    localparam int PTW = XW + YW + RW;

    // Records per object, fixed by the checker
    localparam int NPTS = 6;

    // Counters must be able to hold NPTS itself (buffer-full marker)
    localparam int                CNT_W    = $clog2(NPTS + 1);
    localparam logic [CNT_W-1:0] NPTS_CNT = CNT_W'(NPTS);

    // One receiver record; x occupies the low bits
    typedef struct packed {
        logic [RW-1:0] r;
        logic [YW-1:0] y;
        logic [XW-1:0] x;
    } pt_t;

    function automatic pt_t pack_pt(input logic [XW-1:0] x,
                                    input logic [YW-1:0] y,
                                    input logic [RW-1:0] r);
        pt_t p;
        p.x = x;
        p.y = y;
        p.r = r;
        return p;
    endfunction

endpackage

// File: rtl/geofence_feeder_if.sv
// geofence_feeder_if
//   Bundles the host record stream, the checker-facing point bus and the
//   host result handshake of the geofence feeder.
//   Host stream : in_valid, in_ready, in_x, in_y, in_r
//   Checker     : fence_rst, fence_x, fence_y, fence_r, fence_valid, fence_inside
//   Result      : out_valid, out_ready, out_inside, out_timeout
//   Status      : busy
//   slave  - the feeder side
//   master - the environment side (host plus checker)
interface geofence_feeder_if;
    import geofence_feeder_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [XW-1:0] in_x;
    logic [YW-1:0] in_y;
    logic [RW-1:0] in_r;

    logic          fence_rst;
    logic [XW-1:0] fence_x;
    logic [YW-1:0] fence_y;
    logic [RW-1:0] fence_r;
    logic          fence_valid;
    logic          fence_inside;

    logic          out_valid;
    logic          out_ready;
    logic          out_inside;
    logic          out_timeout;

    logic          busy;

    modport slave (
        input  in_valid, in_x, in_y, in_r, fence_valid, fence_inside, out_ready,
        output in_ready, fence_rst, fence_x, fence_y, fence_r,
               out_valid, out_inside, out_timeout, busy
    );

    modport master (
        output in_valid, in_x, in_y, in_r, fence_valid, fence_inside, out_ready,
        input  in_ready, fence_rst, fence_x, fence_y, fence_r,
               out_valid, out_inside, out_timeout, busy
    );

endinterface

// File: rtl/geofence_pt_buf.sv
// geofence_pt_buf
//   NPTS-entry point register file.
//   clk, reset_n : clock, asynchronous active-low reset (clears all entries)
//   i_wr_en      : write strobe
//   i_wr_idx     : write slot
//   i_wr_data    : record to write
//   i_rd_idx     : read slot (combinational read)
//   o_rd_data    : record at i_rd_idx, zero for an out-of-range slot
module geofence_pt_buf
    import geofence_feeder_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_wr_en,
    input  logic [CNT_W-1:0] i_wr_idx,
    input  pt_t              i_wr_data,
    input  logic [CNT_W-1:0] i_rd_idx,
    output pt_t              o_rd_data
);

    pt_t r_mem [NPTS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NPTS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en && (i_wr_idx < NPTS_CNT)) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    // The read pointer parks at NPTS for one cycle at the end of a launch
    assign o_rd_data = (i_rd_idx < NPTS_CNT) ? r_mem[i_rd_idx] : '0;

endmodule

// File: rtl/geofence_feeder.sv
// geofence_feeder
//   Collects NPTS receiver records from the host, holds the geofence checker
//   in reset until a full set is buffered, releases it and streams the points
//   on consecutive cycles, then returns the checker's verdict (or a watchdog
//   timeout) to the host over a valid/ready handshake.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset; also asserts fence_rst at once
//   bus     : host stream, checker bus, result handshake and busy status
module geofence_feeder
    import geofence_feeder_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int TW      = 7
) (
    input logic             clk,
    input logic             reset_n,
    geofence_feeder_if.slave bus
);

    localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

    state_e           r_state;
    logic [CNT_W-1:0] r_wr_cnt;
    logic [CNT_W-1:0] r_rd_idx;
    logic [TW-1:0]    r_wd;
    logic             r_in_ready;
    logic             r_fence_rst;
    pt_t              r_fence_pt;
    logic             r_out_valid;
    logic             r_out_inside;
    logic             r_out_timeout;
    logic             r_busy;

    state_e           w_state_nxt;
    logic [CNT_W-1:0] w_wr_cnt_nxt;
    logic [CNT_W-1:0] w_wr_cnt_acc;
    logic             w_accept;
    logic             w_wd_expired;
    pt_t              w_wr_pt;
    pt_t              w_rd_pt;

    assign w_accept     = bus.in_valid && r_in_ready;
    assign w_wr_cnt_acc = r_wr_cnt + CNT_W'(w_accept);
    // r_wd holds the number of edges since release; the edge that would make
    // it TIMEOUT is the timeout edge
    assign w_wd_expired = (r_wd == WD_LAST);
    assign w_wr_pt      = pack_pt(bus.in_x, bus.in_y, bus.in_r);

    geofence_pt_buf u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_wr_en   (w_accept),
        .i_wr_idx  (r_wr_cnt),
        .i_wr_data (w_wr_pt),
        .i_rd_idx  (r_rd_idx),
        .o_rd_data (w_rd_pt)
    );

    // Next state and write count; the registered in_ready/busy are derived
    // from these so they are correct in the cycle after each edge.
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_cnt_nxt = w_wr_cnt_acc;
        case (r_state)
            ST_COLLECT: begin
                if (w_wr_cnt_acc == NPTS_CNT) w_state_nxt = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                if (r_rd_idx == NPTS_CNT) begin
                    w_state_nxt  = ST_WAIT;
                    w_wr_cnt_nxt = '0;
                end
            end
            ST_WAIT: begin
                if (bus.fence_valid || w_wd_expired) w_state_nxt = ST_REPORT;
            end
            ST_REPORT: begin
                if (r_out_valid && bus.out_ready) w_state_nxt = ST_COLLECT;
            end
            default: w_state_nxt = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_COLLECT;
            r_wr_cnt      <= '0;
            r_rd_idx      <= '0;
            r_wd          <= '0;
            r_in_ready    <= 1'b1;
            r_fence_rst   <= 1'b1;
            r_fence_pt    <= '0;
            r_out_valid   <= 1'b0;
            r_out_inside  <= 1'b0;
            r_out_timeout <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wr_cnt   <= w_wr_cnt_nxt;
            r_in_ready <= (w_wr_cnt_nxt < NPTS_CNT) && (w_state_nxt != ST_LAUNCH);
            r_busy     <= (w_state_nxt != ST_COLLECT);
            case (r_state)
                ST_COLLECT: begin
                    // Release edge: the checker sees point 0 in the first
                    // cycle out of reset; r_rd_idx is 0 throughout COLLECT.
                    if (w_state_nxt == ST_LAUNCH) begin
                        r_fence_rst <= 1'b0;
                        r_fence_pt  <= w_rd_pt;
                        r_rd_idx    <= CNT_W'(1);
                        r_wd        <= '0;
                    end
                end
                ST_LAUNCH: begin
                    r_wd <= r_wd + 1'b1;
                    if (r_rd_idx == NPTS_CNT) begin
                        r_fence_pt <= '0;
                        r_rd_idx   <= '0;
                    end else begin
                        r_fence_pt <= w_rd_pt;
                        r_rd_idx   <= r_rd_idx + 1'b1;
                    end
                end
                ST_WAIT: begin
                    r_wd <= r_wd + 1'b1;
                    // A result arriving on the timeout edge takes priority
                    if (bus.fence_valid) begin
                        r_out_inside  <= bus.fence_inside;
                        r_out_timeout <= 1'b0;
                        r_out_valid   <= 1'b1;
                        r_fence_rst   <= 1'b1;
                    end else if (w_wd_expired) begin
                        r_out_inside  <= 1'b0;
                        r_out_timeout <= 1'b1;
                        r_out_valid   <= 1'b1;
                        r_fence_rst   <= 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (r_out_valid && bus.out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.fence_rst   = r_fence_rst;
    assign bus.fence_x     = r_fence_pt.x;
    assign bus.fence_y     = r_fence_pt.y;
    assign bus.fence_r     = r_fence_pt.r;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_inside  = r_out_inside;
    assign bus.out_timeout = r_out_timeout;
    assign bus.busy        = r_busy;

endmodule

// File: tb/tb_geofence_feeder.sv
// tb_geofence_feeder
//   Drives host records, a checker stand-in and the host result handshake,
//   and compares every output each cycle with a timeline model of the feeder
//   (record queue, release edge number, pending report).
module tb_geofence_feeder;
    import geofence_feeder_pkg::*;

    localparam int TIMEOUT = 64;
    localparam int TW      = 7;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    geofence_feeder_if bus ();

    geofence_feeder #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_set[$];      // records buffered for the next object
    int m_live[NPTS];  // set being streamed to the checker
    bit m_active;      // checker out of reset
    bit m_report;      // result offered to host
    bit m_inside, m_to;
    int m_rel;         // edge number of the release
    int n;             // edges since the last reset release
    int m_reports;
    int rep_age;

    // ---------------- stimulus state ----------------
    bit h_valid;
    int h_rec;
    int src[$];
    bit rand_mode;
    int p_iv;
    int lat;           // checker answers when sampled at release edge + lat
    int ordy_wait;
    int fv_noise;
    int fi_force;      // -1 random, otherwise fixed fence_inside
    bit d_fv, d_fi, d_ordy;

    function automatic int mkrec(input int x, input int y, input int r);
        return ((r & 32'h7FF) << 20) | ((y & 32'h3FF) << 10) | (x & 32'h3FF);
    endfunction

    function automatic bit exp_in_ready();
        return (m_set.size() < NPTS) && !(m_active && (n - m_rel) < NPTS);
    endfunction

    task automatic model_reset();
        m_set.delete();
        m_active = 0;
        m_report = 0;
        m_inside = 0;
        m_to     = 0;
        rep_age  = 0;
        n        = 0;
        m_rel    = 0;
    endtask

    task automatic model_edge();
        bit pre_collect;
        bit acc;
        bit res;
        int d;
        pre_collect = !m_active && !m_report;
        d   = n - m_rel;
        acc = h_valid && exp_in_ready();
        res = 0;
        if (m_report) begin
            if (d_ordy) m_report = 0;
            else rep_age++;
        end else if (m_active) begin
            if (d == NPTS - 1) m_set.delete();
            if (d >= NPTS) begin
                if (d_fv) begin
                    m_inside = d_fi; m_to = 0; res = 1;
                end else if (d == TIMEOUT - 1) begin
                    m_inside = 0; m_to = 1; res = 1;
                end
            end
        end
        if (res) begin
            m_active = 0; m_report = 1; rep_age = 0; m_reports++;
        end
        if (acc) begin
            m_set.push_back(h_rec);
            h_valid = 0;
        end
        n++;
        if (pre_collect && m_set.size() == NPTS) begin
            m_active = 1;
            m_rel    = n;
            for (int i = 0; i < NPTS; i++) m_live[i] = m_set[i];
        end
    endtask

    task automatic compare_all();
        int  d;
        int  pt;
        d  = n - m_rel;
        pt = (m_active && d < NPTS) ? m_live[d] : 0;
        chk("in_ready",    bus.in_ready,    exp_in_ready());
        chk("fence_rst",   bus.fence_rst,   !m_active);
        chk("fence_x",     bus.fence_x,     pt & 32'h3FF);
        chk("fence_y",     bus.fence_y,     (pt >> 10) & 32'h3FF);
        chk("fence_r",     bus.fence_r,     (pt >> 20) & 32'h7FF);
        chk("out_valid",   bus.out_valid,   m_report);
        chk("out_inside",  bus.out_inside,  m_inside);
        chk("out_timeout", bus.out_timeout, m_to);
        chk("busy",        bus.busy,        m_active || m_report);
    endtask

    task automatic drive_inputs();
        int d;
        if (!h_valid) begin
            if (src.size() > 0) begin
                h_rec = src.pop_front(); h_valid = 1;
            end else if (rand_mode && $urandom_range(99) < p_iv) begin
                h_rec = $urandom & 32'h7FFFFFFF; h_valid = 1;
            end
        end
        d    = n - m_rel;
        d_fv = m_active && (d == lat - 1);
        if (fv_noise > 0 && $urandom_range(99) < fv_noise) d_fv = 1;
        d_fi = (fi_force < 0) ? 1'($urandom_range(1)) : 1'(fi_force);
        if (m_report) d_ordy = (rep_age >= ordy_wait);
        else          d_ordy = rand_mode ? 1'($urandom_range(1)) : 1'b0;
        bus.in_valid     = h_valid;
        bus.in_x         = h_rec[9:0];
        bus.in_y         = h_rec[19:10];
        bus.in_r         = h_rec[30:20];
        bus.fence_valid  = d_fv;
        bus.fence_inside = d_fi;
        bus.out_ready    = d_ordy;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
        drive_inputs();
    endtask

    task automatic run_until(input int target, input int budget);
        int start;
        int k;
        start = m_reports;
        k     = 0;
        while (m_reports < start + target && k < budget) begin
            step();
            k++;
        end
        chk("result_within_budget", (m_reports >= start + target), 1);
    endtask

    task automatic push_random_set();
        for (int i = 0; i < NPTS; i++) src.push_back($urandom & 32'h7FFFFFFF);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not end (t=%0t)", $time);
        $fatal(1);
    end

    initial begin
        int k;
        h_valid = 0; h_rec = 0; rand_mode = 0; p_iv = 0; lat = 1000;
        ordy_wait = 0; fv_noise = 0; fi_force = -1; m_reports = 0;
        d_fv = 0; d_fi = 0; d_ordy = 0;
        bus.in_valid = 0; bus.in_x = '0; bus.in_y = '0; bus.in_r = '0;
        bus.fence_valid = 0; bus.fence_inside = 0; bus.out_ready = 0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        compare_all();
        reset_n = 1'b1;

        // Directed set, checker answers inside after 20 cycles, host stalls 5
        src.push_back(mkrec(0, 0, 5));
        src.push_back(mkrec(10, 0, 5));
        src.push_back(mkrec(15, 8, 5));
        src.push_back(mkrec(10, 16, 5));
        src.push_back(mkrec(0, 16, 5));
        src.push_back(mkrec(5, 8, 5));
        lat = 20; ordy_wait = 5; fi_force = 1;
        drive_inputs();
        run_until(1, 200);
        chk("directed_inside", bus.out_inside, 1);
        chk("directed_no_timeout", bus.out_timeout, 0);

        // Checker never answers: watchdog timeout
        push_random_set();
        lat = 1000; ordy_wait = 0; fi_force = -1;
        run_until(1, 300);
        chk("never_answers_timeout", bus.out_timeout, 1);

        // Result on the timeout edge wins
        push_random_set();
        lat = TIMEOUT; fi_force = 1; ordy_wait = 2;
        run_until(1, 300);
        chk("coincident_result_wins", bus.out_timeout, 0);

        // Next set collected during WAIT, launched right after the handshake
        push_random_set();
        push_random_set();
        lat = 30; ordy_wait = 3; fi_force = -1;
        run_until(2, 500);

        // Reset in the middle of a launch
        push_random_set();
        lat = 30; ordy_wait = 1;
        k = 0;
        while (!(m_active && (n - m_rel) == 3) && k < 300) begin
            step();
            k++;
        end
        chk("reached_mid_launch", (m_active && (n - m_rel) == 3), 1);
        reset_n = 1'b0;
        #1;
        chk("arst_fence_rst", bus.fence_rst, 1);
        chk("arst_in_ready",  bus.in_ready,  1);
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_busy",      bus.busy,      0);
        model_reset();
        h_valid = 0;
        src.delete();
        @(negedge clk);
        compare_all();
        reset_n = 1'b1;
        push_random_set();
        drive_inputs();
        run_until(1, 300);

        // Randomised traffic with stray checker strobes
        rand_mode = 1; p_iv = 70; fv_noise = 3;
        for (int i = 0; i < 20; i++) begin
            lat       = $urandom_range(70, 1);
            ordy_wait = $urandom_range(4);
            run_until(1, 400);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
